reg_file_param: RTL and testbench



---
 rtl/reg_file_param.sv | 78 +++++++
 tb/tb_reg_file_param.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised multi-port register file with strobed writes and optional bypass
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int N_RD     = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD-1:0]          re,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    output logic [N_RD-1:0]          rd_valid,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W/8-1:0]      wstrb
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    generate
        if ((DATA_W % 8) != 0 || N_RD < 1 || N_RD > 4) begin : g_bad_params
            $error("reg_file_param: DATA_W must be a multiple of 8 and N_RD within 1..4");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wmerge;
    logic              wr_en;
    logic [DATA_W-1:0] rdata [N_RD];

    // Post-write image of the addressed register; shared by storage update and bypass.
    always_comb begin
        wmerge = mem[wa];
        for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
                wmerge[8*b +: 8] = wd[8*b +: 8];
            end
        end
    end

    assign wr_en = we && !((ZERO_REG != 0) && (wa == '0));

    always_comb begin
        for (int p = 0; p < N_RD; p++) begin
            rdata[p] = mem[ra[p*ADDR_W +: ADDR_W]];
            if ((ZERO_REG != 0) && (ra[p*ADDR_W +: ADDR_W] == '0)) begin
                rdata[p] = '0;
            end else if ((BYPASS != 0) && wr_en && (ra[p*ADDR_W +: ADDR_W] == wa)) begin
                rdata[p] = wmerge;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
            rd       <= '0;
            rd_valid <= '0;
        end else begin
            if (wr_en) begin
                mem[wa] <= wmerge;
            end
            for (int p = 0; p < N_RD; p++) begin
                if (re[p]) begin
                    rd[p*DATA_W +: DATA_W] <= rdata[p];
                end
            end
            rd_valid <= re;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param in write-first and read-first/zero-reg builds
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  re;
    logic [7:0]  ra;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wstrb;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  rdv_a, rdv_b;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(32), .ADDR_W(4), .N_RD(2), .BYPASS(1), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .re(re), .ra(ra), .rd(rd_a), .rd_valid(rdv_a),
        .we(we), .wa(wa), .wd(wd), .wstrb(wstrb)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(4), .N_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_rf (
        .clk(clk), .rst(rst), .re(re), .ra(ra), .rd(rd_b), .rd_valid(rdv_b),
        .we(we), .wa(wa), .wd(wd), .wstrb(wstrb)
    );

    typedef struct {
        logic [63:0] rd_a;
        logic [1:0]  v_a;
        logic [63:0] rd_b;
        logic [1:0]  v_b;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [31:0] mem_m  [2][16];
    logic [31:0] hold_m [2][2];
    logic [31:0] merged, val;
    logic [63:0] erd [2];
    logic [1:0]  ev [2];
    logic        byp, zr, wen;
    logic [3:0]  pa;

    task automatic step(input string tag, input bit r, input logic [1:0] e, input logic [7:0] a,
                        input bit w, input logic [3:0] adr, input logic [31:0] d, input logic [3:0] s);
        exp_t x, got;
        string t;
        rst = r; re = e; ra = a; we = w; wa = adr; wd = d; wstrb = s;
        for (int k = 0; k < 2; k++) begin
            byp = (k == 0);
            zr  = (k == 1);
            wen = w && !(zr && adr == 4'd0);
            merged = mem_m[k][adr];
            for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
            for (int p = 0; p < 2; p++) begin
                pa = a[4*p +: 4];
                if (r) begin
                    erd[k][32*p +: 32] = 32'd0;
                    ev[k][p] = 1'b0;
                    hold_m[k][p] = 32'd0;
                end else if (e[p]) begin
                    if (zr && pa == 4'd0)             val = 32'd0;
                    else if (byp && wen && pa == adr) val = merged;
                    else                              val = mem_m[k][pa];
                    erd[k][32*p +: 32] = val;
                    ev[k][p] = 1'b1;
                    hold_m[k][p] = val;
                end else begin
                    erd[k][32*p +: 32] = hold_m[k][p];
                    ev[k][p] = 1'b0;
                end
            end
            if (r) begin
                for (int i = 0; i < 16; i++) mem_m[k][i] = 32'(i);
            end else if (wen) begin
                mem_m[k][adr] = merged;
            end
        end
        x.rd_a = erd[0]; x.v_a = ev[0]; x.rd_b = erd[1]; x.v_b = ev[1];
        sb_q.push_back(x);
        tag_q.push_back(tag);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (rd_a === got.rd_a) else begin
            errors++;
            $error("FAIL %s wf.rd observed %h expected %h", t, rd_a, got.rd_a);
        end
        checks++;
        assert (rdv_a === got.v_a) else begin
            errors++;
            $error("FAIL %s wf.rd_valid observed %b expected %b", t, rdv_a, got.v_a);
        end
        checks++;
        assert (rd_b === got.rd_b) else begin
            errors++;
            $error("FAIL %s rf.rd observed %h expected %h", t, rd_b, got.rd_b);
        end
        checks++;
        assert (rdv_b === got.v_b) else begin
            errors++;
            $error("FAIL %s rf.rd_valid observed %b expected %b", t, rdv_b, got.v_b);
        end
    endtask

    initial begin
        rst = 1'b0; re = '0; ra = '0; we = 1'b0; wa = '0; wd = '0; wstrb = '0;
        @(posedge clk);
        #1;
        step("reset",        1, 2'b00, 8'h00, 0, 4'd0, 32'h0,        4'h0);
        step("reset_image",  0, 2'b11, 8'hF5, 0, 4'd0, 32'h0,        4'h0);
        step("byte_write",   0, 2'b00, 8'h00, 1, 4'd3, 32'hAABBCCDD, 4'b0101);
        step("byte_read",    0, 2'b11, 8'h33, 0, 4'd0, 32'h0,        4'h0);
        step("bypass",       0, 2'b01, 8'h07, 1, 4'd7, 32'h12345678, 4'hF);
        step("after_bypass", 0, 2'b01, 8'h07, 0, 4'd0, 32'h0,        4'h0);
        step("zero_write",   0, 2'b00, 8'h00, 1, 4'd0, 32'hFFFFFFFF, 4'hF);
        step("zero_read",    0, 2'b11, 8'h00, 0, 4'd0, 32'h0,        4'h0);
        step("zero_bypass",  0, 2'b11, 8'h00, 1, 4'd0, 32'h0BADF00D, 4'hF);
        step("hold_read",    0, 2'b01, 8'h09, 0, 4'd0, 32'h0,        4'h0);
        for (int i = 0; i < 3; i++)
            step("hold_idle", 0, 2'b00, 8'h5A, 0, 4'd0, 32'h0,       4'h0);
        step("pre_rst_wr",   0, 2'b00, 8'h00, 1, 4'd2, 32'hDEAD0000, 4'hF);
        step("mid_reset",    1, 2'b11, 8'h22, 1, 4'd2, 32'h11111111, 4'hF);
        step("post_reset",   0, 2'b11, 8'h22, 0, 4'd0, 32'h0,        4'h0);
        step("nostrb_byp",   0, 2'b11, 8'h44, 1, 4'd4, 32'hCAFEBABE, 4'h0);
        step("nostrb_read",  0, 2'b10, 8'h40, 0, 4'd0, 32'h0,        4'h0);
        step("hi_strb_byp",  0, 2'b11, 8'hEE, 1, 4'd14, 32'h89ABCDEF, 4'b1010);
        for (int i = 0; i < 40; i++)
            step("random", 0, 2'($urandom), 8'($urandom), 1'($urandom),
                 4'($urandom), $urandom, 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
